// File: rtl/read_vec_tx_ctrl.sv
// read_vec_tx_ctrl: streams vector A or B to the UART byte transmitter, element by element, LSB byte first.
// Optional feature: define READ_VEC_HEADER_EN to send the accepted op code as a header byte ahead of the data.
module read_vec_tx_ctrl #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned LENGTH        = 1024,
   parameter logic [7:0]  OP_READ_VEC_A = 8'h01,
   parameter logic [7:0]  OP_READ_VEC_B = 8'h02
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       op,
   input  logic             op_valid,
   input  logic [WIDTH-1:0] out_a [LENGTH],
   input  logic [WIDTH-1:0] out_b [LENGTH],
   input  logic             tx_busy,
   output logic [7:0]       tx_data,
   output logic             tx_start,
   output logic             is_transmitting,
   output logic             op_finished
);
   localparam int unsigned BYTES = WIDTH / 8;
   localparam int unsigned IW    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IW-1:0] IDX_LAST  = IW'(LENGTH - 1);
   localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);

   typedef enum logic [2:0] {
      IDLE, HDR, LOAD, START, WAIT_ACK, WAIT_DONE, DONE
   } state_t;

   state_t           state_q, state_d;
   logic             sel_b_q, sel_b_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [BW-1:0]    byte_cnt_q, byte_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [7:0]       tx_data_d;
   logic [WIDTH-1:0] elem;
   logic [WIDTH-1:0] shift_shr;
   logic             cmd_ok;
`ifdef READ_VEC_HEADER_EN
   logic             hdr_q, hdr_d;
`endif

   assign elem      = sel_b_q ? out_b[idx_q] : out_a[idx_q];
   assign shift_shr = shift_q >> 8;
   assign cmd_ok    = op_valid && ((op == OP_READ_VEC_A) || (op == OP_READ_VEC_B));

   // Next-state, datapath updates and the transmitter request.
   // tx_data is loaded on the edge entering START/HDR so it is stable while tx_start is high.
   always_comb begin
      state_d    = state_q;
      sel_b_d    = sel_b_q;
      idx_d      = idx_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      tx_data_d  = tx_data;
      tx_start   = 1'b0;
`ifdef READ_VEC_HEADER_EN
      hdr_d      = hdr_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_ok) begin
               sel_b_d    = (op == OP_READ_VEC_B);
               idx_d      = '0;
               byte_cnt_d = '0;
`ifdef READ_VEC_HEADER_EN
               hdr_d      = 1'b1;
               tx_data_d  = op;
               state_d    = HDR;
`else
               state_d    = LOAD;
`endif
            end
         end
`ifdef READ_VEC_HEADER_EN
         HDR: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = WAIT_ACK;
            end
         end
`endif
         LOAD: begin
            shift_d    = elem;
            byte_cnt_d = '0;
            tx_data_d  = elem[7:0];
            state_d    = START;
         end
         START: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (tx_busy) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
`ifdef READ_VEC_HEADER_EN
               if (hdr_q) begin
                  hdr_d   = 1'b0;
                  state_d = LOAD;
               end else
`endif
               if (byte_cnt_q != BYTE_LAST) begin
                  shift_d    = shift_shr;
                  byte_cnt_d = byte_cnt_q + BW'(1);
                  tx_data_d  = shift_shr[7:0];
                  state_d    = START;
               end else if (idx_q != IDX_LAST) begin
                  idx_d   = idx_q + IW'(1);
                  state_d = LOAD;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; status flags follow the next state so they align with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         sel_b_q         <= 1'b0;
         idx_q           <= '0;
         byte_cnt_q      <= '0;
         shift_q         <= '0;
         tx_data         <= 8'h00;
         is_transmitting <= 1'b0;
         op_finished     <= 1'b0;
`ifdef READ_VEC_HEADER_EN
         hdr_q           <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         sel_b_q         <= sel_b_d;
         idx_q           <= idx_d;
         byte_cnt_q      <= byte_cnt_d;
         shift_q         <= shift_d;
         tx_data         <= tx_data_d;
         is_transmitting <= (state_d != IDLE);
         op_finished     <= (state_d == DONE);
`ifdef READ_VEC_HEADER_EN
         hdr_q           <= hdr_d;
`endif
      end
   end

endmodule

// File: doc/read_vec_tx_ctrl.md
# read_vec_tx_ctrl

- Sequences the transmission of one coprocessor vector (A or B) to the host, byte by byte, through the UART byte transmitter.
- Sits between the vector register banks (out_a/out_b) and the transmitter.
- On an accepted readVec_A / readVec_B command it walks the selected vector from index 0 to LENGTH-1, splits each element into bytes, and handshakes each byte with the transmitter.
- Signals op_finished when the last byte has left.

## Interface
- WIDTH, 8, element width in bits; must be a multiple of 8; BYTES = WIDTH/8.
- LENGTH, 1024, number of elements per vector; index width IW = $clog2(LENGTH).
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op  in  8  command code; only `readVec_A` and `readVec_B` are acted on.
- op_valid  in  1  single-cycle strobe qualifying op.
- out_a  in  WIDTH x LENGTH  vector A (unpacked array); the caller holds it stable while is_transmitting=1.
- out_b  in  WIDTH x LENGTH  vector B; same stability rule.
- tx_busy  in  1  transmitter busy.
- tx_data  out  8  byte to send; registered.
- tx_start  out  1  one-cycle request to the transmitter.
- is_transmitting  out  1  high from the cycle after acceptance until the op_finished cycle, inclusive.
- op_finished  out  1  one-cycle pulse at the end of a transfer.

## Operation
- **States:** IDLE, HDR (only with macro), LOAD, START, WAIT_ACK, WAIT_DONE, DONE.
- **IDLE → accept:**
  - An op_valid=1 with op equal to `readVec_A` or `readVec_B` is accepted.
  - The vector select (0=A, 1=B) is latched, idx=0, byte_cnt=0.
  - Next state is LOAD, or HDR when the macro is enabled.
- **Ignored commands:**
  - Any other op code is ignored: no outputs change.
  - op_valid outside IDLE is ignored, with no effect on the running transfer.
- **LOAD:**
  - The selected vector element [idx] is captured into a WIDTH-bit shift register.
  - byte_cnt=0; next state START.
- **START:**
  - Waits while tx_busy=1.
  - When tx_busy=0: tx_start=1 for that cycle, tx_data = shift[7:0] (or the header byte in HDR); next state WAIT_ACK.
- **WAIT_ACK:** waits for tx_busy=1, then moves to WAIT_DONE.
- **WAIT_DONE:** waits for tx_busy=0, then takes the first matching branch:
  - byte_cnt < BYTES-1: shift register >> 8, byte_cnt++, go to START. Bytes go out least-significant first.
  - idx < LENGTH-1: idx++, go to LOAD.
  - otherwise: go to DONE.
- **DONE:** op_finished=1 for one cycle, then IDLE; is_transmitting drops on the next cycle.
- **Byte count:** the total per transfer is exactly LENGTH*BYTES, plus 1 with the header.
- **Counters:** idx never wraps; the terminal compare is idx == LENGTH-1.
- **tx_data:** holds its last value between starts.

## Timing
- **Reset values:** tx_data=0x00, tx_start=0, is_transmitting=0, op_finished=0, state IDLE, idx=0.
- **Acceptance latency:** accept at cycle N (macro off):
  - N+1: LOAD, is_transmitting=1.
  - N+2: START; first tx_start at N+2 if tx_busy=0.
- **Per-byte overhead:** 3 cycles (START, WAIT_ACK detect, WAIT_DONE detect) plus the transmitter busy time; add 1 cycle (LOAD) per new element.
- **Transfer end:** tx_busy falls in cycle M on the last byte → op_finished=1 at M+1 → is_transmitting=0 at M+2.
- **Back-to-back:** a new op_valid is accepted in the first IDLE cycle (M+2).
- **Reset mid-transfer:** the state returns to IDLE on the next edge. tx_start and is_transmitting are 0 the following cycle, and no op_finished is issued. A byte already in the transmitter is not recalled.
- **Reset priority:** reset has priority over op_valid in the same cycle.
- **tx_busy already high in START:** the controller stalls without issuing tx_start; there is no timeout.

## Configuration
- **READ_VEC_HEADER_EN defined:**
  - After acceptance the controller enters HDR: one byte equal to the latched op code is sent through the START/WAIT_ACK/WAIT_DONE handshake, then LOAD.
  - The first data tx_start shifts later by the header's duration.
- **Undefined:** HDR is absent and acceptance goes straight to LOAD; no header byte is sent.

## Test plan
- WIDTH=8, LENGTH=4, out_a={0x11,0x22,0x33,0x44}, op=`readVec_A` strobe, transmitter model busy 10 cycles → exactly four tx_start pulses with tx_data 0x11,0x22,0x33,0x44; op_finished one cycle after the last busy fall.
- Same setup with out_b={0xA0,0xB0,0xC0,0xD0} and op=`readVec_B` → bytes 0xA0,0xB0,0xC0,0xD0; out_a is never sent.
- WIDTH=16, LENGTH=2, out_a={0xA55A,0x1234} → bytes 0x5A,0xA5,0x34,0x12 in order.
- op=0x00 with op_valid → no tx_start and is_transmitting stays 0. op_valid with `readVec_B` in the middle of a readVec_A transfer → ignored, and the A bytes continue.
- Reset asserted after the second tx_start of a LENGTH=4 transfer → outputs 0 the next cycle, no op_finished. A new readVec_A then restarts at element 0x11.
- READ_VEC_HEADER_EN defined, op=`readVec_A` → first byte equals the `readVec_A` code, then 0x11..0x44; five tx_start pulses total.
